// File: rtl/led_value_ctrl.sv
// LED effect code controller: turns vending front-end pulses into a registered
// 4-bit LED effect code, times the transient effects and issues a beep request.
module led_value_ctrl #(
    parameter logic [27:0] SUCCESS_TIME = 28'd100_000_000,
    parameter logic [27:0] CANCEL_TIME  = 28'd50_000_000,
    parameter logic [27:0] TEST_TIME    = 28'd25_000_000,
    parameter logic [27:0] SEL_TIMEOUT  = 28'd250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_vld,
    input  logic [1:0] sel_item,
    input  logic       buy_ok,
    input  logic       cancel,
    input  logic       lamp_test,
    output logic [3:0] value,
    output logic       beep_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SUCCESS,
        ST_CANCEL,
        ST_TEST
    } state_t;

    state_t      state, state_n;
    logic [27:0] timer, timer_n;
    logic [1:0]  item, item_n;
    logic [3:0]  value_n;
    logic        beep_n;
    logic        busy_n;

    always_comb begin
        state_n = state;
        timer_n = timer + 28'd1;
        item_n  = item;
        case (state)
            ST_IDLE: begin
                timer_n = '0;
                if (sel_vld) begin
                    state_n = ST_SELECT;
                    item_n  = sel_item;
                end else if (lamp_test) begin
                    state_n = ST_TEST;
                end
            end
            ST_SELECT: begin
                if (cancel) begin
                    state_n = ST_CANCEL;
                    timer_n = '0;
                end else if (buy_ok) begin
                    state_n = ST_SUCCESS;
                    timer_n = '0;
                end else if (sel_vld) begin
                    item_n  = sel_item;
                    timer_n = '0;
                end else if (timer == SEL_TIMEOUT - 28'd1) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end
            end
            ST_SUCCESS: begin
                if (timer == SUCCESS_TIME - 28'd1) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end
            end
            ST_CANCEL: begin
                if (timer == CANCEL_TIME - 28'd1) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end
            end
            ST_TEST: begin
                if (timer == TEST_TIME - 28'd1) begin
                    state_n = ST_IDLE;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so they register on the same edge.
    always_comb begin
        value_n = 4'd0;
        busy_n  = 1'b0;
        case (state_n)
            ST_SELECT:  value_n = 4'd2 + {2'b00, item_n};
            ST_SUCCESS: begin value_n = 4'd6; busy_n = 1'b1; end
            ST_CANCEL:  begin value_n = 4'd7; busy_n = 1'b1; end
            ST_TEST:    begin value_n = 4'd1; busy_n = 1'b1; end
            default:    value_n = 4'd0;
        endcase
        beep_n = (state_n != state) &&
                 ((state_n == ST_SUCCESS) || (state_n == ST_CANCEL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            item     <= '0;
            value    <= '0;
            beep_req <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            item     <= item_n;
            value    <= value_n;
            beep_req <= beep_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: doc/led_value_ctrl.md
Name: led_value_ctrl

Overview:
Control-side producer of the 4-bit LED effect code consumed by the board's LED driver (0 off, 1 all on, 2..5 single LED item 0..3, 6 running light, 7 flash). It turns item-select, purchase-confirm, cancel and lamp-test pulses from the vending front end into a registered value code. It times the transient effects (success, cancel, lamp test) and returns the code to idle on its own. It also issues a one-cycle beep request whenever a success or cancel effect starts.

Parameters:
SUCCESS_TIME, 28'd100_000_000, cycles code 6 is held after a purchase (2 s at 50 MHz)
CANCEL_TIME, 28'd50_000_000, cycles code 7 is held after a cancel (1 s)
TEST_TIME, 28'd25_000_000, cycles code 1 is held for lamp test (0.5 s)
SEL_TIMEOUT, 28'd250_000_000, idle cycles in SELECT before automatic return to IDLE (5 s)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
sel_vld  input  1  one-cycle pulse: item selection strobe
sel_item  input  2  item index 0..3, sampled when sel_vld=1
buy_ok  input  1  one-cycle pulse: payment complete
cancel  input  1  one-cycle pulse: order cancelled
lamp_test  input  1  one-cycle pulse: request all-LED test
value  output  4  LED effect code to the LED driver (registered)
beep_req  output  1  one-cycle pulse on entry to SUCCESS or CANCEL
busy  output  1  high while in SUCCESS, CANCEL or TEST

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, timer=0, value=0, beep_req=0, busy=0, latched item=0. Reset overrides all inputs, including mid-effect.
- All outputs are registered. value, busy and beep_req reflect an accepted event on the first clk edge after the input cycle (latency 1).
- States and their value codes: IDLE=0, SELECT=2+item, SUCCESS=6, CANCEL=7, TEST=1.
- IDLE:
  - sel_vld -> SELECT; latch sel_item.
  - lamp_test -> TEST.
  - buy_ok and cancel are ignored.
  - If sel_vld and lamp_test arrive together, sel_vld wins.
- SELECT:
  - Priority: cancel > buy_ok > sel_vld.
  - cancel -> CANCEL.
  - buy_ok -> SUCCESS.
  - sel_vld -> stay in SELECT, relatch item (value changes), restart the timeout.
  - lamp_test is ignored.
  - No event for SEL_TIMEOUT consecutive cycles -> IDLE, value=0, no beep.
- SUCCESS / CANCEL / TEST: all inputs are ignored and busy=1. The state lasts exactly SUCCESS_TIME / CANCEL_TIME / TEST_TIME cycles, measured from the first cycle value shows the code, then goes to IDLE.
- Timer:
  - 28-bit, cleared to 0 on every state entry and on every accepted sel_vld in SELECT.
  - Increments each cycle in SELECT, SUCCESS, CANCEL and TEST.
  - Leaving condition is timer == LIMIT-1. At that edge, state <= IDLE and timer <= 0.
  - Timer never wraps: the limit is always reached first.
- beep_req: high for exactly the first cycle of SUCCESS and of CANCEL; never in TEST or SELECT.
- busy falls in the same cycle value returns to 0.
- Unused codes 8..15 are never driven.

Test Plan:
- Parameters overridden for all tests: SUCCESS_TIME=10, CANCEL_TIME=6, TEST_TIME=4, SEL_TIMEOUT=20.
- Reset then idle: value=0, busy=0, beep_req=0. buy_ok and cancel pulses in IDLE -> no change.
- sel_vld with item=2, then buy_ok 5 cycles later -> value=4 from the next cycle, then value=6. beep_req high for exactly 1 cycle, busy=1 for exactly 10 cycles, then value=0 and busy=0.
- sel_vld item=0, then cancel and buy_ok in the same cycle -> value=7 (cancel wins), beep_req 1 cycle, 6 cycles later value=0. sel_vld during CANCEL is ignored.
- sel_vld item=3, no further events -> value=5 for 20 cycles then 0. A second sel_vld item=1 at cycle 15 -> value=3, timeout restarts, and value returns to 0 twenty cycles after that second pulse.
- lamp_test in IDLE -> value=1, busy=1 for 4 cycles, beep_req stays 0. lamp_test while in SELECT -> ignored.
- rst asserted on cycle 3 of SUCCESS -> next edge value=0, busy=0, beep_req=0. A following sel_vld item=1 -> value=3 with a fresh timeout.
